// File: rtl/tail_light_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tail_light_input_cond
//  Purpose  : Front end for the Thunderbird tail-light sequencer. Derives the
//             50%-duty Clk_2Hz clock, synchronises and debounces the three
//             raw switches, and updates LEFT/RIGHT/HAZ only on the falling
//             edge of Clk_2Hz so the sequencer gets half a period of setup.
//  Revision : 1.0  initial release
// ============================================================================
module tail_light_input_cond #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int OUT_HZ          = 2,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic SW_LEFT,
    input  logic SW_RIGHT,
    input  logic SW_HAZ,
    output logic Clk_2Hz,
    output logic LEFT,
    output logic RIGHT,
    output logic HAZ
);

    localparam int HALF  = CLK_HZ / (2 * OUT_HZ);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             fall_tick;
    logic [2:0]       raw;
    logic [2:0]       stable;

    // Channel order: bit 0 = left, bit 1 = right, bit 2 = hazard
    assign raw = {SW_HAZ, SW_RIGHT, SW_LEFT};

    // Last count of a half period while the clock is high: the next edge is the fall
    assign fall_tick = (div_cnt == DIV_LAST) && Clk_2Hz;

    // Free-running half-period counter; Clk_2Hz toggles at its wrap
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div_cnt <= '0;
            Clk_2Hz <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            Clk_2Hz <= ~Clk_2Hz;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < 3; ch++) begin : g_chan
            logic            sync1;
            logic            sync2;
            logic            stable_q;
            logic [DB_W-1:0] db_cnt;

            // Two-flop synchroniser for the asynchronous switch input
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                end else begin
                    sync1 <= raw[ch];
                    sync2 <= sync1;
                end
            end

            // Accept a new level only after it differs from stable for DEBOUNCE_CYCLES clocks
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    stable_q <= 1'b0;
                    db_cnt   <= '0;
                end else if (sync2 == stable_q) begin
                    db_cnt   <= '0;
                end else if (db_cnt == DB_LAST) begin
                    stable_q <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt   <= db_cnt + DB_W'(1);
                end
            end

            assign stable[ch] = stable_q;
        end
    endgenerate

    // Present all three conditioned levels together on the Clk_2Hz falling edge
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            LEFT  <= 1'b0;
            RIGHT <= 1'b0;
            HAZ   <= 1'b0;
        end else if (fall_tick) begin
            LEFT  <= stable[0];
            RIGHT <= stable[1];
            HAZ   <= stable[2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tail_light_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tail_light_input_cond
//  Purpose  : Randomised self-checking bench for tail_light_input_cond with a
//             behavioural model built from per-edge input history.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tail_light_input_cond;

    localparam int HALF = 4;
    localparam int DEB  = 3;

    logic       Clk;
    logic       Rst;
    logic [2:0] sw;
    logic       Clk_2Hz;
    logic       LEFT;
    logic       RIGHT;
    logic       HAZ;

    int n_checks;
    int n_errors;
    bit mon_en;

    tail_light_input_cond #(
        .CLK_HZ         (16),
        .OUT_HZ         (2),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .SW_LEFT (sw[0]),
        .SW_RIGHT(sw[1]),
        .SW_HAZ  (sw[2]),
        .Clk_2Hz (Clk_2Hz),
        .LEFT    (LEFT),
        .RIGHT   (RIGHT),
        .HAZ     (HAZ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // samples[e-1] holds the raw switches seen at edge e after reset release.
    logic [2:0] samples[$];
    int         m_edge;
    logic [2:0] m_stable;
    logic [2:0] m_out;
    logic       m_clk2;

    // Value reaching the debouncer at edge k: raw input two edges earlier, 0 before that
    function automatic logic [2:0] delayed_at(int k);
        if (k < 3) return 3'b000;
        return samples[k-3];
    endfunction

    always @(posedge Clk or posedge Rst) begin : model_step
        logic [2:0] d;
        bit         all_diff;
        if (Rst) begin
            samples.delete();
            m_edge   = 0;
            m_stable = 3'b000;
            m_out    = 3'b000;
            m_clk2   = 1'b0;
        end else begin
            m_edge++;
            // every 2*HALF edges the generated clock falls and samples the old stable values
            if (m_edge % (2 * HALF) == 0) m_out = m_stable;
            samples.push_back(sw);
            for (int c = 0; c < 3; c++) begin
                all_diff = 1'b1;
                for (int k = m_edge - DEB + 1; k <= m_edge; k++) begin
                    d = delayed_at(k);
                    if (d[c] == m_stable[c]) all_diff = 1'b0;
                end
                if (all_diff) m_stable[c] = ~m_stable[c];
            end
            m_clk2 = ((m_edge / HALF) % 2) == 1;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge Clk) begin
        if (mon_en && !Rst) begin
            check_value("clk_2hz", Clk_2Hz, m_clk2);
            check_value("left",    LEFT,    m_out[0]);
            check_value("right",   RIGHT,   m_out[1]);
            check_value("haz",     HAZ,     m_out[2]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_random(input int cycles);
        int hold[3];
        for (int c = 0; c < 3; c++) hold[c] = $urandom_range(1, 10);
        for (int n = 0; n < cycles; n++) begin
            @(negedge Clk);
            for (int c = 0; c < 3; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    sw[c] = ~sw[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2)
                                                          : $urandom_range(3, 24);
                end
            end
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge Clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        Rst      = 1'b1;
        sw       = 3'b000;

        idle(3);
        check_value("rst_clk_2hz", Clk_2Hz, 0);
        check_value("rst_left",    LEFT,    0);
        check_value("rst_right",   RIGHT,   0);
        check_value("rst_haz",     HAZ,     0);

        #2 Rst = 1'b0;
        mon_en = 1'b1;

        // idle period, then left switch raised just after edge 8
        idle(8);
        sw[0] = 1'b1;
        idle(20);

        // hazard glitches of 2 and 1 clocks, then a real hold
        sw[2] = 1'b1; idle(2); sw[2] = 1'b0; idle(3);
        sw[2] = 1'b1; idle(1); sw[2] = 1'b0; idle(12);
        sw[2] = 1'b1; idle(5); sw[2] = 1'b0; idle(20);

        // left and right changing one clock apart, both ways
        sw[0] = 1'b0; idle(20);
        sw[0] = 1'b1; idle(1); sw[1] = 1'b1; idle(20);
        sw[0] = 1'b0; idle(1); sw[1] = 1'b0; idle(20);

        run_random(600);

        // asynchronous reset while Clk_2Hz and LEFT are both high
        sw = 3'b001;
        for (int i = 0; i < 200 && !(m_out[0] && m_clk2); i++) @(negedge Clk);
        check_value("mid_pre_left", LEFT,    1);
        check_value("mid_pre_clk",  Clk_2Hz, 1);
        #2 Rst = 1'b1;
        #1;
        check_value("mid_rst_clk_2hz", Clk_2Hz, 0);
        check_value("mid_rst_left",    LEFT,    0);
        check_value("mid_rst_right",   RIGHT,   0);
        check_value("mid_rst_haz",     HAZ,     0);
        idle(3);
        #2 Rst = 1'b0;
        idle(30);

        run_random(1500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
